// File: rtl/nor_deserializer.sv
// rtl/nor_deserializer.sv - Serial-to-parallel NOR deserializer with framing checks
//
// Purpose: collects WIDTH serial beats (LSB first), stores NOR(in_a, in_b) of
// each beat, and presents the assembled word on a valid/ready output. Frames
// that end early, or run past WIDTH beats, raise a one-cycle frame_err.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - serial beat valid
//   in_a       - operand A bit, LSB first
//   in_b       - operand B bit, LSB first
//   in_last    - final beat of a frame
//   in_ready   - beat accept (low while a word is held)
//   out_valid  - assembled word available
//   out_data   - assembled NOR word
//   out_ready  - downstream accept
//   frame_err  - one-cycle framing-error pulse
module nor_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_HOLD    = 2'd1,
        S_DROP    = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_frame_err;

    logic             w_accept;
    logic             w_bit;
    logic             w_at_end;
    logic [WIDTH-1:0] w_word;

    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign frame_err = r_frame_err;

    assign w_accept = in_valid && in_ready;
    assign w_bit    = ~(in_a | in_b);
    assign w_at_end = (r_cnt == CNT_MAX);

    // Partial word with the current beat merged in; used both to advance the
    // shift word and to load the complete word on the final beat.
    always_comb begin
        w_word        = r_word;
        w_word[r_cnt] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_cnt       <= '0;
            r_word      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_at_end) begin
                            r_cnt  <= '0;
                            r_word <= '0;
                            if (in_last) begin
                                r_out_data  <= w_word;
                                r_out_valid <= 1'b1;
                                r_state     <= S_HOLD;
                            end else begin
                                // Long frame: flag once, then swallow the tail.
                                r_frame_err <= 1'b1;
                                r_state     <= S_DROP;
                            end
                        end else if (in_last) begin
                            // Short frame: flag and restart collection.
                            r_frame_err <= 1'b1;
                            r_cnt       <= '0;
                            r_word      <= '0;
                        end else begin
                            r_word <= w_word;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // in_ready is low for the whole HOLD state, including the
                    // handshake cycle, so no beat can slip in alongside it.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_COLLECT;
                    end
                end
                S_DROP: begin
                    if (w_accept && in_last) begin
                        r_state <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/nor_deserializer.md
NOR_DESERIALIZER -- requirements
Module: nor_deserializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, the output word width and the number of serial beats per frame.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port: in_valid  input  1  serial beat valid.
REQ-005 SHALL have port: in_a  input  1  serial operand A bit, LSB first.
REQ-006 SHALL have port: in_b  input  1  serial operand B bit, LSB first.
REQ-007 SHALL have port: in_last  input  1  marks the final beat of a frame.
REQ-008 SHALL have port: in_ready  output  1  beat accept.
REQ-009 SHALL have port: out_valid  output  1  assembled word available.
REQ-010 SHALL have port: out_data  output  WIDTH  assembled NOR word.
REQ-011 SHALL have port: out_ready  input  1  downstream accept.
REQ-012 SHALL have port: frame_err  output  1  one-cycle framing-error pulse.

Function
REQ-013 SHALL accept a beat on any rising edge where in_valid and in_ready are both 1; no state change SHALL occur on any other beat.
REQ-014 SHALL store NOR(in_a, in_b) of each accepted beat at bit index cnt of an internal shift word; cnt counts 0..WIDTH-1, LSB first.
REQ-015 SHALL implement the states COLLECT, HOLD and DROP; in_ready SHALL be 1 in COLLECT and DROP and 0 in HOLD.
REQ-016 SHALL, in COLLECT, on an accepted beat with cnt=WIDTH-1 and in_last=1, load out_data with the complete word, assert out_valid on the next cycle (1-cycle latency), reset cnt to 0 and enter HOLD.
REQ-017 SHALL, in COLLECT, on an accepted beat with cnt<WIDTH-1 and in_last=1 (short frame), pulse frame_err for exactly one cycle, discard the partial word, reset cnt to 0 and stay in COLLECT.
REQ-018 SHALL, in COLLECT, on an accepted beat with cnt=WIDTH-1 and in_last=0 (long frame), pulse frame_err for one cycle, discard the word, reset cnt to 0 and enter DROP.
REQ-019 SHALL, in DROP, consume and ignore beats until an accepted beat with in_last=1, then enter COLLECT with cnt=0; no further frame_err SHALL be raised in DROP.
REQ-020 SHALL, in HOLD, keep out_valid=1 and out_data stable until out_valid and out_ready are both 1, then deassert out_valid on the next cycle and enter COLLECT.
REQ-021 SHALL NOT accept an input beat in the cycle of the output handshake; the first new beat is accepted one cycle later (no bypass).
REQ-022 SHALL produce cnt wrap only via REQ-016/017/018; cnt SHALL never exceed WIDTH-1.
REQ-023 SHALL treat in_valid=0 cycles mid-frame as stalls that preserve cnt and the partial word.

Reset
REQ-024 SHALL, when rst_n=0 at a rising edge, set state=COLLECT, cnt=0, out_valid=0, out_data=0, frame_err=0, with in_ready=1 from the first cycle after reset.
REQ-025 SHALL discard any partial frame, held word or DROP condition on reset mid-operation, with no frame_err pulse.

Verification
REQ-026 SHALL be verified with a=0x0F, b=0x30 sent LSB first over 8 beats, in_last on beat 8, out_ready=1 -> out_valid high 1 cycle after beat 8, out_data=0xC0.
REQ-027 SHALL be verified by sending 3 beats with in_last on beat 3 -> one-cycle frame_err pulse, no out_valid; a following valid frame with a=b=0x00 -> out_data=0xFF.
REQ-028 SHALL be verified by sending 10 beats, in_last on beat 10 -> frame_err pulses once after beat 8, beats 9-10 are ignored, and the next valid frame (a=0xAA, b=0x00) -> out_data=0x55.
REQ-029 SHALL be verified by holding out_ready=0 for 5 cycles after a frame completes -> out_data stable, in_ready=0 throughout; out_ready=1 -> out_valid drops next cycle, in_ready rises.
REQ-030 SHALL be verified by inserting in_valid=0 gaps mid-frame (a=0xFF, b=0xFF) -> out_data=0x00, and by asserting rst_n=0 after beat 4 -> all outputs 0, and the next full frame decodes correctly.
